// File: rtl/am_iq_receiver.sv
// am_iq_receiver: 1-bit AM receive chain. Quadrature mixer, 5-stage CIC decimators
// on both arms, then a bit-serial floor(sqrt(I^2+Q^2)) magnitude demodulator.
module am_iq_receiver #(
    parameter int DATA_WIDTH           = 12,
    parameter int CIC_REGISTER_WIDTH   = 72,
    parameter int CIC_DECIMATION_RATIO = 4096,
    parameter int CIC_GAIN_WIDTH       = 2
) (
    input  logic                         clk,
    input  logic                         arst_n,
    input  logic                         rf_in,
    input  logic signed [DATA_WIDTH-1:0] lo_sin,
    input  logic signed [DATA_WIDTH-1:0] lo_cos,
    input  logic [CIC_GAIN_WIDTH-1:0]    gain,
    output logic                         rf_out,
    output logic signed [DATA_WIDTH-1:0] mix_i,
    output logic signed [DATA_WIDTH-1:0] mix_q,
    output logic signed [DATA_WIDTH-1:0] cic_i,
    output logic signed [DATA_WIDTH-1:0] cic_q,
    output logic                         cic_valid,
    output logic signed [DATA_WIDTH-1:0] amdemod_out,
    output logic                         demod_valid
);
    localparam int DW = DATA_WIDTH;
    localparam int W  = CIC_REGISTER_WIDTH;
    localparam int CW = $clog2(CIC_DECIMATION_RATIO);
    localparam int RW = DW + 4;
    localparam int SW = $clog2(DW);

    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} sqrt_state_e;

    logic                       rf_d, rf_q;
    logic signed [DW-1:0]       mixer_d [2], mixer_q [2];
    logic signed [W-1:0]        integ_d [2][5], integ_q [2][5];
    logic signed [W-1:0]        dly_d [2][5], dly_q [2][5];
    logic signed [W-1:0]        comb_d [2], comb_q [2];
    logic [CW-1:0]              cnt_d, cnt_q;
    logic                       comb_load_s;
    logic                       comb_valid_d, comb_valid_q;
    logic [CIC_GAIN_WIDTH-1:0]  gsel_d, gsel_q;
    logic signed [DW-1:0]       cic_out_d [2], cic_out_q [2];
    logic                       cic_vld_d, cic_vld_q;
    sqrt_state_e                state_d, state_q;
    logic [2*DW-1:0]            rad_d, rad_q;
    logic [RW-1:0]              rem_d, rem_q;
    logic [DW-1:0]              root_d, root_q;
    logic [SW-1:0]              step_d, step_q;
    logic [DW-1:0]              amd_d, amd_q;
    logic                       demod_vld_d, demod_vld_q;
    logic signed [2*DW-1:0]     ext_i_s, ext_q_s, sq_i_s, sq_q_s;
    logic [2*DW-1:0]            mag2_s;
    logic [RW-1:0]              rem_shift_s, trial_s;

    // Mixer: multiplying by +/-1 is a pass-through or a one's complement.
    always_comb begin
        rf_d       = rf_in;
        mixer_d[0] = rf_in ? lo_sin : ~lo_sin;
        mixer_d[1] = rf_in ? lo_cos : ~lo_cos;
    end

    // CIC integrators every cycle; combs only on the decimation slot.
    always_comb begin
        logic signed [W-1:0] acc;
        cnt_d        = cnt_q + CW'(1);
        comb_load_s  = (cnt_q == CW'(CIC_DECIMATION_RATIO - 1));
        comb_valid_d = comb_load_s;
        gsel_d       = comb_load_s ? gain : gsel_q;
        for (int a = 0; a < 2; a++) begin
            integ_d[a][0] = integ_q[a][0] + {{(W-DW){mixer_q[a][DW-1]}}, mixer_q[a]};
            for (int s = 1; s < 5; s++) begin
                integ_d[a][s] = integ_q[a][s] + integ_q[a][s-1];
            end
            acc = integ_q[a][4];
            for (int s = 0; s < 5; s++) begin
                dly_d[a][s] = comb_load_s ? acc : dly_q[a][s];
                acc         = acc - dly_q[a][s];
            end
            comb_d[a] = comb_load_s ? acc : comb_q[a];
        end
    end

    // Gain-selected slice of the comb result, saturating when the dropped bits are not sign copies.
    always_comb begin
        logic signed [W-1:0] shifted;
        logic [W-DW:0]       hi;
        cic_vld_d = comb_valid_q;
        for (int a = 0; a < 2; a++) begin
            shifted = comb_q[a] >>> (W - DW - int'(gsel_q));
            hi      = shifted[W-1:DW-1];
            if (!comb_valid_q) begin
                cic_out_d[a] = cic_out_q[a];
            end else if ((&hi) || !(|hi)) begin
                cic_out_d[a] = shifted[DW-1:0];
            end else if (shifted[W-1]) begin
                cic_out_d[a] = {1'b1, {(DW-1){1'b0}}};
            end else begin
                cic_out_d[a] = {1'b0, {(DW-1){1'b1}}};
            end
        end
    end

    // Restoring square root, one root bit per cycle, started by cic_valid.
    always_comb begin
        ext_i_s     = {{DW{cic_out_q[0][DW-1]}}, cic_out_q[0]};
        ext_q_s     = {{DW{cic_out_q[1][DW-1]}}, cic_out_q[1]};
        sq_i_s      = ext_i_s * ext_i_s;
        sq_q_s      = ext_q_s * ext_q_s;
        mag2_s      = sq_i_s + sq_q_s;
        rem_shift_s = (rem_q << 2) | RW'(rad_q[2*DW-1 -: 2]);
        trial_s     = {2'b00, root_q, 2'b01};
        state_d     = state_q;
        rad_d       = rad_q;
        rem_d       = rem_q;
        root_d      = root_q;
        step_d      = step_q;
        amd_d       = amd_q;
        demod_vld_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cic_vld_q) begin
                    rad_d   = mag2_s;
                    rem_d   = '0;
                    root_d  = '0;
                    step_d  = '0;
                    state_d = ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                rad_d = rad_q << 2;
                if (rem_shift_s >= trial_s) begin
                    rem_d  = rem_shift_s - trial_s;
                    root_d = {root_q[DW-2:0], 1'b1};
                end else begin
                    rem_d  = rem_shift_s;
                    root_d = {root_q[DW-2:0], 1'b0};
                end
                if (step_q == SW'(DW - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    step_d = step_q + SW'(1);
                end
            end
            ST_DONE: begin
                amd_d       = root_q[DW-1] ? {1'b0, {(DW-1){1'b1}}} : root_q;
                demod_vld_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All state registers; arst_n clears everything immediately.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rf_q         <= 1'b0;
            cnt_q        <= '0;
            comb_valid_q <= 1'b0;
            gsel_q       <= '0;
            cic_vld_q    <= 1'b0;
            state_q      <= ST_IDLE;
            rad_q        <= '0;
            rem_q        <= '0;
            root_q       <= '0;
            step_q       <= '0;
            amd_q        <= '0;
            demod_vld_q  <= 1'b0;
            for (int a = 0; a < 2; a++) begin
                mixer_q[a]   <= '0;
                comb_q[a]    <= '0;
                cic_out_q[a] <= '0;
                for (int s = 0; s < 5; s++) begin
                    integ_q[a][s] <= '0;
                    dly_q[a][s]   <= '0;
                end
            end
        end else begin
            rf_q         <= rf_d;
            cnt_q        <= cnt_d;
            comb_valid_q <= comb_valid_d;
            gsel_q       <= gsel_d;
            cic_vld_q    <= cic_vld_d;
            state_q      <= state_d;
            rad_q        <= rad_d;
            rem_q        <= rem_d;
            root_q       <= root_d;
            step_q       <= step_d;
            amd_q        <= amd_d;
            demod_vld_q  <= demod_vld_d;
            for (int a = 0; a < 2; a++) begin
                mixer_q[a]   <= mixer_d[a];
                comb_q[a]    <= comb_d[a];
                cic_out_q[a] <= cic_out_d[a];
                for (int s = 0; s < 5; s++) begin
                    integ_q[a][s] <= integ_d[a][s];
                    dly_q[a][s]   <= dly_d[a][s];
                end
            end
        end
    end

    assign rf_out      = rf_q;
    assign mix_i       = mixer_q[0];
    assign mix_q       = mixer_q[1];
    assign cic_i       = cic_out_q[0];
    assign cic_q       = cic_out_q[1];
    assign cic_valid   = cic_vld_q;
    assign amdemod_out = $signed(amd_q);
    assign demod_valid = demod_vld_q;

endmodule

// File: tb/tb_am_iq_receiver.sv
// Bench for am_iq_receiver at a short decimation ratio; the CIC reference is the
// direct convolution with five length-R boxcars, the demod reference is integer sqrt.
module tb_am_iq_receiver;
    localparam int DW   = 12;
    localparam int R    = 32;
    localparam int W    = DW + 5 * 5;
    localparam int GW   = 2;
    localparam int HLEN = 5 * (R - 1) + 1;

    logic                 clk = 1'b0;
    logic                 arst_n;
    logic                 rf_in;
    logic signed [DW-1:0] lo_sin, lo_cos;
    logic [GW-1:0]        gain;
    logic                 rf_out, cic_valid, demod_valid;
    logic signed [DW-1:0] mix_i, mix_q, cic_i, cic_q, amdemod_out;

    always #5 clk = ~clk;

    am_iq_receiver #(
        .DATA_WIDTH(DW), .CIC_REGISTER_WIDTH(W),
        .CIC_DECIMATION_RATIO(R), .CIC_GAIN_WIDTH(GW)
    ) dut (
        .clk(clk), .arst_n(arst_n), .rf_in(rf_in), .lo_sin(lo_sin), .lo_cos(lo_cos),
        .gain(gain), .rf_out(rf_out), .mix_i(mix_i), .mix_q(mix_q), .cic_i(cic_i),
        .cic_q(cic_q), .cic_valid(cic_valid), .amdemod_out(amdemod_out),
        .demod_valid(demod_valid)
    );

    int     n_cmp = 0;
    int     n_err = 0;
    longint h [HLEN];
    int     m_i[$], m_q[$], g_hist[$];
    int     edge_n, dm_due, first_cv, last_cv, last_dv, cv_cnt, dv_cnt;
    longint exp_ci, exp_cq, exp_am, dm_val;

    task automatic check_val(input string tag, input logic signed [63:0] obs,
                             input logic signed [63:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp_v, edge_n);
        end
    endtask

    function automatic void build_h();
        longint cur[$];
        longint nxt[$];
        cur.push_back(1);
        repeat (5) begin
            nxt.delete();
            for (int i = 0; i < cur.size() + R - 1; i++) nxt.push_back(0);
            for (int i = 0; i < cur.size(); i++)
                for (int j = 0; j < R; j++) nxt[i+j] += cur[i];
            cur = nxt;
        end
        for (int i = 0; i < HLEN; i++) h[i] = cur[i];
    endfunction

    function automatic longint clamp(input longint v, input longint lo, input longint hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic longint isqrt(input longint v);
        longint r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    // Output published at edge n was loaded at edge n-1 from mixer samples up to edge n-7.
    function automatic longint cic_model(input int arm, input int n, input int g);
        longint y = 0;
        longint v;
        for (int j = 0; j < HLEN; j++) begin
            int idx;
            idx = n - 7 - j;
            if (idx >= 0) y += h[j] * longint'((arm == 0) ? m_i[idx] : m_q[idx]);
        end
        v = y >>> (W - DW - g);
        return clamp(v, -2048, 2047);
    endfunction

    task automatic run_cycle();
        int mi, mq;
        bit cv_exp, dv_exp;
        @(posedge clk);
        edge_n++;
        mi = rf_in ? int'(lo_sin) : -int'(lo_sin) - 1;
        mq = rf_in ? int'(lo_cos) : -int'(lo_cos) - 1;
        m_i.push_back(mi);
        m_q.push_back(mq);
        g_hist.push_back(int'(gain));
        #1;
        check_val("rf_out", rf_out, rf_in);
        check_val("mix_i", mix_i, mi);
        check_val("mix_q", mix_q, mq);
        cv_exp = (edge_n > R) && ((edge_n - 1) % R == 0);
        if (cv_exp) begin
            exp_ci = cic_model(0, edge_n, g_hist[edge_n-1]);
            exp_cq = cic_model(1, edge_n, g_hist[edge_n-1]);
            dm_due = edge_n + DW + 2;
            dm_val = clamp(isqrt(exp_ci * exp_ci + exp_cq * exp_cq), 0, 2047);
        end
        check_val("cic_valid", cic_valid, cv_exp);
        check_val("cic_i", cic_i, exp_ci);
        check_val("cic_q", cic_q, exp_cq);
        dv_exp = (edge_n == dm_due);
        if (dv_exp) exp_am = dm_val;
        check_val("demod_valid", demod_valid, dv_exp);
        check_val("amdemod_out", amdemod_out, exp_am);
        if (cic_valid) begin
            if (first_cv == 0) begin
                first_cv = edge_n;
                check_val("first_cv_edge", edge_n, R + 1);
            end else begin
                check_val("cv_spacing", edge_n - last_cv, R);
            end
            last_cv = edge_n;
            cv_cnt++;
        end
        if (demod_valid) begin
            check_val("demod_latency", edge_n - last_cv, DW + 2);
            if (last_dv != 0) check_val("dv_spacing", edge_n - last_dv, R);
            last_dv = edge_n;
            dv_cnt++;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 arst_n = 1'b0;
        #1;
        check_val("rst_rf_out", rf_out, 0);
        check_val("rst_mix_i", mix_i, 0);
        check_val("rst_mix_q", mix_q, 0);
        check_val("rst_cic_i", cic_i, 0);
        check_val("rst_cic_q", cic_q, 0);
        check_val("rst_cic_valid", cic_valid, 0);
        check_val("rst_amdemod", amdemod_out, 0);
        check_val("rst_demod_valid", demod_valid, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        edge_n = 0;
        m_i.delete(); m_q.delete(); g_hist.delete();
        m_i.push_back(0); m_q.push_back(0); g_hist.push_back(0);
        exp_ci = 0; exp_cq = 0; exp_am = 0; dm_due = -1;
        first_cv = 0; last_cv = 0; last_dv = 0;
    endtask

    task automatic seg(input bit rf, input int s, input int c, input int g, input int ncyc);
        rf_in  = rf;
        lo_sin = DW'(s);
        lo_cos = DW'(c);
        gain   = GW'(g);
        repeat (ncyc) run_cycle();
    endtask

    task automatic rand_inputs();
        rf_in  = 1'($urandom);
        lo_sin = DW'($urandom);
        lo_cos = DW'($urandom);
        if ($urandom_range(0, 1) == 0) begin
            lo_sin = lo_sin >>> 3;
            lo_cos = lo_cos >>> 3;
        end
    endtask

    initial begin
        build_h();
        arst_n = 1'b1;
        rf_in  = 1'b0;
        lo_sin = '0;
        lo_cos = '0;
        gain   = '0;
        do_reset();

        rf_in = 1'b1; lo_sin = 12'sd100; run_cycle();
        check_val("mix_dir_pos", mix_i, 100);
        rf_in = 1'b0; run_cycle();
        check_val("mix_dir_neg", mix_i, -101);
        lo_sin = -12'sd2048; run_cycle();
        check_val("mix_dir_min", mix_i, 2047);
        rf_in = 1'b1; run_cycle();
        check_val("rf_out_dir", rf_out, 1);
        seg(1'b0, 0, 0, 0, 8 * R - 4);

        seg(1'b1, 2047, 0, 0, 8 * R);
        check_val("dc_cic_i", cic_i, 2047);
        check_val("dc_cic_q", cic_q, 0);
        check_val("dc_amdemod", amdemod_out, 2047);
        seg(1'b1, 100, 0, 1, 8 * R);
        check_val("gain1_cic_i", cic_i, 200);
        seg(1'b1, 1024, 0, 1, 8 * R);
        check_val("gain1_sat_pos", cic_i, 2047);
        seg(1'b1, -1024, 0, 1, 8 * R);
        check_val("gain1_neg", cic_i, -2048);
        seg(1'b1, 300, 400, 0, 8 * R);
        check_val("mag_345", amdemod_out, 500);
        seg(1'b1, 2047, 2047, 0, 8 * R);
        check_val("mag_clamp", amdemod_out, 2047);
        seg(1'b1, -300, -400, 0, 8 * R);
        check_val("mag_neg", amdemod_out, 500);

        for (int c = 0; c < 20 * R; c++) begin
            if (c % R == 0) gain = GW'($urandom_range(0, 3));
            rand_inputs();
            run_cycle();
        end

        cv_cnt = 0;
        dv_cnt = 0;
        repeat (5 * R) run_cycle();
        check_val("cv_count", cv_cnt, 5);
        check_val("dv_count", dv_cnt, 5);

        while (edge_n % R != 6) begin
            rand_inputs();
            run_cycle();
        end
        do_reset();
        for (int c = 0; c < 10 * R; c++) begin
            if (c % R == 3) gain = GW'($urandom_range(0, 3));
            rand_inputs();
            run_cycle();
        end
        check_val("post_rst_first_cv", first_cv, R + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
